// File: rtl/if_id_queue_pkg.sv
// Shared CPU definitions for the fetch/decode boundary: reset constants and the
// fetch-word bundle carried from IF into ID.
package if_id_queue_pkg;

  localparam logic [31:0] NOP_INST = 32'd0;
  localparam logic [31:0] RESET_PC = 32'd0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] inst;
  } fetch_word_t;

endpackage

// File: rtl/if_id_queue_mem.sv
// Storage for the IF/ID queue: registered write on push, combinational read at
// the head pointer. Contents are not reset; validity is tracked by the control.
module if_id_queue_mem
  import if_id_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  fetch_word_t       wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output fetch_word_t       rdata_o
);

  fetch_word_t mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/if_id_queue.sv
// In-order queue between a non-stallable fetch stage and decode. Squashes
// wrong-path words after a redirect and flags overflow / redirect mismatches.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned AW     = 2,
  parameter int unsigned SHADOW = 1
) (
  input  logic        Clk,
  input  logic        Clrn,
  input  logic [31:0] IF_PC,
  input  logic [31:0] IF_PC4,
  input  logic [31:0] IF_Inst,
  input  logic        MEM_PCSrc,
  input  logic [31:0] MEM_Btarg_or_Jtarg,
  input  logic        ID_Stall,
  output logic [31:0] ID_PC,
  output logic [31:0] ID_PC4,
  output logic [31:0] ID_Inst,
  output logic        ID_Valid,
  output logic        Q_Full,
  output logic        Q_Overflow,
  output logic        Redir_Mismatch
);

  localparam int unsigned SW = (SHADOW > 0) ? $clog2(SHADOW + 1) : 1;
  localparam logic [AW:0]   FullCnt    = (AW + 1)'(DEPTH);
  localparam logic [SW-1:0] ShadowLoad = SW'(SHADOW);

  logic [AW-1:0] rptr_q, rptr_d, wptr_q, wptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [SW-1:0] shadow_q, shadow_d;
  logic [31:0]   tgt_q, tgt_d;
  logic          chk_q, chk_d;
  logic          ovf_q, ovf_d;
  logic          mis_q, mis_d;

  logic          valid, pop, cand, push, drop_full;
  fetch_word_t   head, wword;

  assign valid     = (cnt_q != '0);
  assign pop       = valid & ~ID_Stall & ~MEM_PCSrc;
  assign cand      = ~MEM_PCSrc & (shadow_q == '0);
  assign push      = cand & ((cnt_q != FullCnt) | pop);
  assign drop_full = cand & (cnt_q == FullCnt) & ~pop;

  assign wword = '{pc: IF_PC, pc4: IF_PC4, inst: IF_Inst};

  always_comb begin
    rptr_d   = rptr_q;
    wptr_d   = wptr_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    tgt_d    = tgt_q;
    chk_d    = chk_q;
    ovf_d    = ovf_q;
    mis_d    = mis_q;
    if (MEM_PCSrc) begin
      // Flush wins over push and pop; stall is irrelevant on this edge.
      rptr_d   = '0;
      wptr_d   = '0;
      cnt_d    = '0;
      shadow_d = ShadowLoad;
      tgt_d    = MEM_Btarg_or_Jtarg;
      chk_d    = 1'b1;
    end else begin
      if (shadow_q != '0) shadow_d = shadow_q - 1'b1;
      if (push) wptr_d = wptr_q + 1'b1;
      if (pop)  rptr_d = rptr_q + 1'b1;
      if (push && !pop)      cnt_d = cnt_q + 1'b1;
      else if (pop && !push) cnt_d = cnt_q - 1'b1;
      if (drop_full) ovf_d = 1'b1;
      if (push && chk_q) begin
        chk_d = 1'b0;
        if (IF_PC != tgt_q) mis_d = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      rptr_q   <= '0;
      wptr_q   <= '0;
      cnt_q    <= '0;
      // Discards the fetch reset word, which duplicates PC 0.
      shadow_q <= SW'(1);
      tgt_q    <= '0;
      chk_q    <= 1'b0;
      ovf_q    <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      rptr_q   <= rptr_d;
      wptr_q   <= wptr_d;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      tgt_q    <= tgt_d;
      chk_q    <= chk_d;
      ovf_q    <= ovf_d;
      mis_q    <= mis_d;
    end
  end

  if_id_queue_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk_i   (Clk),
    .we_i    (push),
    .waddr_i (wptr_q),
    .wdata_i (wword),
    .raddr_i (rptr_q),
    .rdata_o (head)
  );

  assign ID_Valid       = valid;
  assign ID_PC          = valid ? head.pc   : '0;
  assign ID_PC4         = valid ? head.pc4  : '0;
  assign ID_Inst        = valid ? head.inst : NOP_INST;
  assign Q_Full         = (cnt_q == FullCnt);
  assign Q_Overflow     = ovf_q;
  assign Redir_Mismatch = mis_q;

endmodule

// File: tb/tb_if_id_queue.sv
// Directed, table-driven bench for if_id_queue with hand-written redirect and
// mid-operation reset sequences.
module tb_if_id_queue;

  logic        Clk = 1'b0;
  logic        Clrn = 1'b0;
  logic [31:0] IF_PC = '0, IF_PC4 = '0, IF_Inst = '0;
  logic        MEM_PCSrc = 1'b0;
  logic [31:0] MEM_Btarg_or_Jtarg = '0;
  logic        ID_Stall = 1'b0;
  logic [31:0] ID_PC, ID_PC4, ID_Inst;
  logic        ID_Valid, Q_Full, Q_Overflow, Redir_Mismatch;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        do_rst;
    logic [31:0] pc;
    logic        stall;
    logic        pcsrc;
    logic [31:0] tgt;
    logic        ev;
    logic [31:0] epc;
    logic        efull;
    logic        eovf;
    logic        emis;
  } vec_t;

  vec_t vecs[$];

  if_id_queue #(
    .DEPTH  (4),
    .AW     (2),
    .SHADOW (1)
  ) dut (
    .Clk                (Clk),
    .Clrn               (Clrn),
    .IF_PC              (IF_PC),
    .IF_PC4             (IF_PC4),
    .IF_Inst            (IF_Inst),
    .MEM_PCSrc          (MEM_PCSrc),
    .MEM_Btarg_or_Jtarg (MEM_Btarg_or_Jtarg),
    .ID_Stall           (ID_Stall),
    .ID_PC              (ID_PC),
    .ID_PC4             (ID_PC4),
    .ID_Inst            (ID_Inst),
    .ID_Valid           (ID_Valid),
    .Q_Full             (Q_Full),
    .Q_Overflow         (Q_Overflow),
    .Redir_Mismatch     (Redir_Mismatch)
  );

  always #5 Clk = ~Clk;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_out(input string nm, input logic ev, input logic [31:0] epc,
                           input logic efull, input logic eovf, input logic emis);
    chk({nm, ".valid"}, {31'd0, ID_Valid}, {31'd0, ev});
    chk({nm, ".pc"},    ID_PC,   ev ? epc : 32'd0);
    chk({nm, ".pc4"},   ID_PC4,  ev ? epc + 32'd4 : 32'd0);
    chk({nm, ".inst"},  ID_Inst, ev ? inst_of(epc) : 32'd0);
    chk({nm, ".full"},  {31'd0, Q_Full},         {31'd0, efull});
    chk({nm, ".ovf"},   {31'd0, Q_Overflow},     {31'd0, eovf});
    chk({nm, ".mis"},   {31'd0, Redir_Mismatch}, {31'd0, emis});
  endtask

  // Asserts reset asynchronously, checks the reset state while it is held,
  // then releases it 1 time unit after a rising edge.
  task automatic apply_reset();
    MEM_PCSrc = 1'b0;
    ID_Stall  = 1'b0;
    Clrn      = 1'b0;
    #1;
    check_out("reset", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    tick();
    Clrn = 1'b1;
  endtask

  task automatic run_row(input vec_t v, input string nm);
    if (v.do_rst) apply_reset();
    IF_PC              = v.pc;
    IF_PC4             = v.pc + 32'd4;
    IF_Inst            = inst_of(v.pc);
    ID_Stall           = v.stall;
    MEM_PCSrc          = v.pcsrc;
    MEM_Btarg_or_Jtarg = v.tgt;
    check_out(nm, v.ev, v.epc, v.efull, v.eovf, v.emis);
    tick();
  endtask

  task automatic add(input logic r, input logic [31:0] pc, input logic st, input logic ps,
                     input logic [31:0] tg, input logic ev, input logic [31:0] epc,
                     input logic ef, input logic eo, input logic em);
    vec_t v;
    v = '{r, pc, st, ps, tg, ev, epc, ef, eo, em};
    vecs.push_back(v);
  endtask

  task automatic hrow(input string nm, input logic [31:0] pc, input logic st,
                      input logic ps, input logic [31:0] tg, input logic ev,
                      input logic [31:0] epc, input logic ef, input logic eo,
                      input logic em);
    vec_t v;
    v = '{1'b0, pc, st, ps, tg, ev, epc, ef, eo, em};
    run_row(v, nm);
  endtask

  initial begin
    // rst  pc     stall src tgt  valid epc    full ovf mis
    // Free run: reset word dropped, head follows one cycle behind the push.
    add(1, 32'h00, 0, 0, 0, 0, 32'h00, 0, 0, 0);
    add(0, 32'h00, 0, 0, 0, 0, 32'h00, 0, 0, 0);
    add(0, 32'h04, 0, 0, 0, 1, 32'h00, 0, 0, 0);
    add(0, 32'h08, 0, 0, 0, 1, 32'h04, 0, 0, 0);
    add(0, 32'h0C, 0, 0, 0, 1, 32'h08, 0, 0, 0);
    // Stall six cycles: fill to four, drop 0x20/0x24, then drain in order.
    add(1, 32'h0C, 0, 0, 0, 0, 32'h00, 0, 0, 0);
    add(0, 32'h10, 1, 0, 0, 0, 32'h00, 0, 0, 0);
    add(0, 32'h14, 1, 0, 0, 1, 32'h10, 0, 0, 0);
    add(0, 32'h18, 1, 0, 0, 1, 32'h10, 0, 0, 0);
    add(0, 32'h1C, 1, 0, 0, 1, 32'h10, 0, 0, 0);
    add(0, 32'h20, 1, 0, 0, 1, 32'h10, 1, 0, 0);
    add(0, 32'h24, 1, 0, 0, 1, 32'h10, 1, 1, 0);
    add(0, 32'h28, 0, 0, 0, 1, 32'h10, 1, 1, 0);
    add(0, 32'h2C, 0, 0, 0, 1, 32'h14, 1, 1, 0);
    add(0, 32'h30, 0, 0, 0, 1, 32'h18, 1, 1, 0);
    add(0, 32'h34, 0, 0, 0, 1, 32'h1C, 1, 1, 0);
    // Full with simultaneous push/pop across the pointer wrap, no overflow.
    add(1, 32'h00, 0, 0, 0, 0, 32'h00, 0, 0, 0);
    add(0, 32'h40, 1, 0, 0, 0, 32'h00, 0, 0, 0);
    add(0, 32'h44, 1, 0, 0, 1, 32'h40, 0, 0, 0);
    add(0, 32'h48, 1, 0, 0, 1, 32'h40, 0, 0, 0);
    add(0, 32'h4C, 1, 0, 0, 1, 32'h40, 0, 0, 0);
    add(0, 32'h50, 0, 0, 0, 1, 32'h40, 1, 0, 0);
    add(0, 32'h54, 0, 0, 0, 1, 32'h44, 1, 0, 0);
    add(0, 32'h58, 0, 0, 0, 1, 32'h48, 1, 0, 0);
    add(0, 32'h5C, 0, 0, 0, 1, 32'h4C, 1, 0, 0);
    add(0, 32'h60, 0, 0, 0, 1, 32'h50, 1, 0, 0);
    add(0, 32'h64, 0, 0, 0, 1, 32'h54, 1, 0, 0);
    // Redirect to 0x100 with three queued; stall asserted on the flush edge.
    add(1, 32'h00, 0, 0, 0, 0, 32'h00, 0, 0, 0);
    add(0, 32'h20, 1, 0, 0, 0, 32'h00, 0, 0, 0);
    add(0, 32'h24, 1, 0, 0, 1, 32'h20, 0, 0, 0);
    add(0, 32'h28, 1, 0, 0, 1, 32'h20, 0, 0, 0);
    add(0, 32'h30, 1, 1, 32'h100, 1, 32'h20, 0, 0, 0);
    add(0, 32'h34, 0, 0, 0, 0, 32'h00, 0, 0, 0);
    add(0, 32'h100, 0, 0, 0, 0, 32'h00, 0, 0, 0);
    add(0, 32'h104, 0, 0, 0, 1, 32'h100, 0, 0, 0);
    add(0, 32'h108, 0, 0, 0, 1, 32'h104, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      run_row(vecs[i], $sformatf("row%0d", i));
    end

    // Redirect whose first pushed word misses the target: flag sticks, word kept.
    apply_reset();
    hrow("mis0", 32'h00, 0, 0, 0, 0, 32'h00, 0, 0, 0);
    hrow("mis1", 32'h00, 1, 0, 0, 0, 32'h00, 0, 0, 0);
    hrow("mis2", 32'h04, 1, 0, 0, 1, 32'h00, 0, 0, 0);
    hrow("mis3", 32'h08, 0, 1, 32'h200, 1, 32'h00, 0, 0, 0);
    hrow("mis4", 32'h0C, 0, 0, 0, 0, 32'h00, 0, 0, 0);
    hrow("mis5", 32'h204, 0, 0, 0, 0, 32'h00, 0, 0, 0);
    hrow("mis6", 32'h208, 0, 0, 0, 1, 32'h204, 0, 0, 1);
    hrow("mis7", 32'h20C, 0, 0, 0, 1, 32'h208, 0, 0, 1);
    // Back-to-back redirects: the second reloads shadow and target.
    hrow("rel0", 32'h210, 0, 1, 32'h2F0, 1, 32'h20C, 0, 0, 1);
    hrow("rel1", 32'h214, 0, 1, 32'h300, 0, 32'h00, 0, 0, 1);
    hrow("rel2", 32'h218, 0, 0, 0, 0, 32'h00, 0, 0, 1);
    hrow("rel3", 32'h300, 0, 0, 0, 0, 32'h00, 0, 0, 1);
    hrow("rel4", 32'h304, 0, 0, 0, 1, 32'h300, 0, 0, 1);
    hrow("rel5", 32'h308, 1, 0, 0, 1, 32'h304, 0, 0, 1);

    // Two entries queued and mismatch set: reset must clear everything at once.
    apply_reset();
    hrow("rst0", 32'h00, 0, 0, 0, 0, 32'h00, 0, 0, 0);
    hrow("rst1", 32'h00, 0, 0, 0, 0, 32'h00, 0, 0, 0);
    hrow("rst2", 32'h04, 0, 0, 0, 1, 32'h00, 0, 0, 0);
    hrow("rst3", 32'h08, 0, 0, 0, 1, 32'h04, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Receiving end of the instruction-fetch interface. Captures the per-cycle IF outputs (PC, PC+4, instruction) into a small in-order queue and presents them to the decode stage.
- Needed because the fetch stage has no stall input: it advances every cycle whether decode is ready or not.
- Consumes the same redirect pair that fetch consumes (MEM_PCSrc, MEM_Btarg_or_Jtarg) to squash wrong-path words.
- Sits between the fetch stage and the decode stage in the pipelined CPU top level.

Parameters:
- DEPTH, 4, number of queue entries; must be a power of 2 and at least 2.
- AW, 2, pointer width; equals log2(DEPTH).
- SHADOW, 1, number of fetch words still wrong-path in the cycle after redirect assertion.

Ports:
- Clk  in  1  clock, rising edge.
- Clrn  in  1  asynchronous active-low reset.
- IF_PC  in  32  PC of the current fetch word.
- IF_PC4  in  32  PC+4 of the current fetch word.
- IF_Inst  in  32  current fetch instruction.
- MEM_PCSrc  in  1  redirect taken this cycle.
- MEM_Btarg_or_Jtarg  in  32  redirect target; used only for the debug compare.
- ID_Stall  in  1  decode cannot accept this cycle.
- ID_PC  out  32  head entry PC.
- ID_PC4  out  32  head entry PC+4.
- ID_Inst  out  32  head instruction; 0 (NOP) when empty.
- ID_Valid  out  1  head entry is valid.
- Q_Full  out  1  count equals DEPTH.
- Q_Overflow  out  1  sticky; a fetch word was dropped because the queue was full.
- Redir_Mismatch  out  1  sticky; the first pushed word after a redirect had IF_PC not equal to the latched target.

Behaviour:
- Reset (async, Clrn=0):
  - Pointers = 0, count = 0.
  - Shadow counter = 1, which discards the fetch reset word (PC 0, Inst 0) that duplicates PC 0.
  - Q_Overflow = 0, Redir_Mismatch = 0, expect-check flag = 0.
  - Outputs: ID_Valid = 0, ID_PC = 0, ID_PC4 = 0, ID_Inst = 0.
  - Storage contents do not matter.
- Every cycle the fetch word is a push candidate. It is pushed at the rising edge only if all of the following hold:
  - MEM_PCSrc = 0;
  - shadow counter = 0;
  - count < DEPTH, or a pop occurs in the same cycle.
- Pop occurs at the edge when ID_Valid = 1 and ID_Stall = 0.
- Simultaneous push and pop:
  - Allowed at any count, including full; count is unchanged.
  - If the queue is empty, only the push takes effect (there is no pop).
- Latency:
  - A pushed word is visible on ID_* in the cycle after its push edge.
  - There is no combinational bypass from IF_* to ID_*.
- Head outputs are read combinationally from registered storage at the read pointer.
  - When count = 0: ID_Valid = 0 and all ID_* data = 0.
- Pointers wrap modulo DEPTH.
  - Count is AW+1 bits wide.
  - Q_Full = (count == DEPTH).
- Overflow:
  - Condition: push conditions hold except count = DEPTH and there is no pop.
  - The word is dropped and Q_Overflow is set until reset.
  - Existing entries are untouched.
- Redirect (MEM_PCSrc = 1 in cycle t):
  - At edge t, all entries are flushed: count = 0 and pointers are aligned.
  - The cycle-t fetch word is dropped.
  - Shadow counter is loaded with SHADOW, so the cycle t+1 word is also dropped.
  - Target is latched and expect-check = 1.
  - Flush has priority over push and pop. ID_Stall is ignored for that edge.
- Shadow counter:
  - Decrements by 1 per cycle while it is nonzero and MEM_PCSrc = 0.
  - A new MEM_PCSrc during the shadow reloads it and the latched target.
- Expect-check:
  - On the first push with expect-check = 1, compare IF_PC to the latched target.
  - On inequality, set Redir_Mismatch (sticky).
  - Clear expect-check after that push.
- Reset asserted mid-operation returns everything to reset state immediately. Nothing in flight is preserved.

Decomposition:
- Shared CPU package:
  - NOP_INST = 32'd0.
  - RESET_PC = 32'd0.
  - A fetch-word bundle typedef {pc, pc4, inst} of 96 bits, also usable by the ID stage.
- One natural sub-module: if_id_queue_mem.
  - DEPTH x 96 register array.
  - Synchronous write on push, asynchronous read at the read pointer, no reset.
- The control path (pointers, count, shadow, flags) stays in if_id_queue.

Test Plan:
- Reset then free-run, ID_Stall = 0, fetch PC 0, 0, 4, 8 on consecutive cycles -> the duplicate PC 0 word is dropped; ID_PC sequence is 0, 4, 8, each one cycle after its push; ID_Valid = 1 from the second cycle after reset release.
- ID_Stall = 1 for 6 cycles with fetch streaming PC 0x10..0x24 -> queue holds 0x10, 0x14, 0x18, 0x1C; Q_Full = 1; 0x20 and 0x24 are dropped; Q_Overflow = 1; releasing the stall drains exactly those four in order.
- Full queue with ID_Stall = 0 while fetch keeps pushing -> simultaneous push and pop; count stays 4; no overflow; order preserved across pointer wrap.
- Queue holding 3 entries, MEM_PCSrc = 1 with target 0x100; fetch shows 0x30 (cycle t), 0x34 (t+1), 0x100 (t+2) -> ID_Valid = 0 at t+1 and t+2; ID_PC = 0x100 at t+3; Redir_Mismatch = 0.
- Same redirect but fetch presents 0x104 at t+2 -> Redir_Mismatch = 1 and stays set; the word is still enqueued.
- Clrn pulsed low for 1 cycle with 2 entries queued and the shadow counter active -> ID_Valid = 0 and all flags = 0 immediately; after release the duplicate PC 0 reset word is dropped.
